// File: rtl/reg_bank_porta_seq.sv
// Burst sequencer for port A of a register bank: write bursts with constant or
// incrementing fill, and read bursts returned on a valid/ready response channel.
module reg_bank_porta_seq #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLKA,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_inc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] addrA,
    output logic [DATA_W-1:0] data_inA,
    output logic              weA,
    input  logic [DATA_W-1:0] data_outA
);

    localparam int unsigned LEN_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               inc_q, inc_d;

    logic               cmd_ready_d, rsp_valid_d, rsp_last_d, done_d, busy_d, we_d;
    logic [DATA_W-1:0]  rsp_rdata_d, data_in_d;
    logic [ADDR_W-1:0]  rsp_addr_d, addr_d;

    logic               accept_c, last_c;

    assign accept_c = cmd_valid && cmd_ready;
    assign last_c   = (cnt_q == len_q);

    // State, burst context and every output are flops; reset aborts any burst.
    always_ff @(posedge CLKA or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            inc_q     <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            weA       <= 1'b0;
            addrA     <= '0;
            data_inA  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            inc_q     <= inc_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_last  <= rsp_last_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_addr  <= rsp_addr_d;
            done      <= done_d;
            busy      <= busy_d;
            weA       <= we_d;
            addrA     <= addr_d;
            data_inA  <= data_in_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = cmd_write ? WR : RD_ADDR;
            WR:      if (last_c) state_d = IDLE;
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RD_RESP;
            RD_RESP: if (rsp_ready) state_d = last_c ? IDLE : RD_ADDR;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and burst context.
    always_comb begin
        cmd_ready_d = 1'b0;
        done_d      = 1'b0;
        we_d        = 1'b0;
        addr_d      = addrA;
        data_in_d   = data_inA;
        rsp_valid_d = rsp_valid;
        rsp_last_d  = rsp_last;
        rsp_rdata_d = rsp_rdata;
        rsp_addr_d  = rsp_addr;
        len_d       = len_q;
        cnt_d       = cnt_q;
        inc_d       = inc_q;
        busy_d      = (state_d != IDLE);

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = !accept_c;
                if (accept_c) begin
                    len_d  = cmd_len;
                    inc_d  = cmd_inc;
                    cnt_d  = '0;
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        we_d      = 1'b1;
                        data_in_d = cmd_wdata;
                    end
                end
            end
            WR: begin
                if (last_c) begin
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = addrA + ADDR_W'(1);
                    data_in_d = inc_q ? data_inA + DATA_W'(1) : data_inA;
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            RD_ADDR: ;
            RD_WAIT: begin
                // Bank data for addrA is valid this cycle; capture it.
                rsp_valid_d = 1'b1;
                rsp_rdata_d = data_outA;
                rsp_addr_d  = addrA;
                rsp_last_d  = last_c;
            end
            RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (last_c) begin
                        done_d      = 1'b1;
                        cmd_ready_d = 1'b1;
                    end else begin
                        addr_d = addrA + ADDR_W'(1);
                        cnt_d  = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_bank_porta_seq.sv
// Directed bench for reg_bank_porta_seq with a behavioural synchronous bank on port A.
module tb_reg_bank_porta_seq;

    logic       CLKA = 1'b0;
    logic       RST_N;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_inc;
    logic [3:0] cmd_addr, cmd_len;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_last, done, busy, weA;
    logic [7:0] rsp_rdata, data_inA;
    logic [7:0] data_outA = 8'h00;
    logic [3:0] rsp_addr, addrA;

    logic [7:0] bank    [16];
    logic [7:0] exp_mem [16];
    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_porta_seq #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLKA(CLKA), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_inc(cmd_inc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .done(done), .busy(busy),
        .addrA(addrA), .data_inA(data_inA), .weA(weA), .data_outA(data_outA)
    );

    always #5 CLKA = ~CLKA;

    // Synchronous bank: write on weA, registered read of addrA.
    always @(posedge CLKA) begin
        if (weA) bank[addrA] <= data_inA;
        data_outA <= bank[addrA];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLKA);
        #1;
    endtask

    // done and rsp_valid are mutually exclusive at all times.
    always @(negedge CLKA) check("done_rsp_excl", 32'(done & rsp_valid), 32'd0);

    task automatic wait_ready;
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic scramble_cmd;
        cmd_valid = 1'b0;
        cmd_write = ~cmd_write;
        cmd_addr  = 4'h7;
        cmd_len   = 4'h9;
        cmd_wdata = 8'hEE;
        cmd_inc   = ~cmd_inc;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l,
                            input logic [7:0] d, input logic inc);
        logic [7:0] ed;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
        cmd_wdata = d; cmd_inc = inc;
        tick();
        scramble_cmd();
        for (int k = 0; k <= int'(l); k++) begin
            ed = inc ? 8'(d + 8'(k)) : d;
            check("wr_we", 32'(weA), 32'd1);
            check("wr_addr", 32'(addrA), 32'(4'(a + 4'(k))));
            check("wr_data", 32'(data_inA), 32'(ed));
            check("wr_ready", 32'(cmd_ready), 32'd0);
            check("wr_busy", 32'(busy), 32'd1);
            check("wr_norsp", 32'(rsp_valid), 32'd0);
            check("wr_nodone", 32'(done), 32'd0);
            exp_mem[4'(a + 4'(k))] = ed;
            tick();
        end
        check("wr_end_we", 32'(weA), 32'd0);
        check("wr_done", 32'(done), 32'd1);
        check("wr_end_ready", 32'(cmd_ready), 32'd1);
        check("wr_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l,
                           input int stall_beat, input int stall_n);
        logic [3:0] ea;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
        cmd_wdata = 8'h00; cmd_inc = 1'b0;
        tick();
        scramble_cmd();
        for (int k = 0; k <= int'(l); k++) begin
            ea = 4'(a + 4'(k));
            check("rd_addr_a", 32'(addrA), 32'(ea));
            check("rd_addr_we", 32'(weA), 32'd0);
            check("rd_addr_nov", 32'(rsp_valid), 32'd0);
            tick();
            check("rd_wait_nov", 32'(rsp_valid), 32'd0);
            tick();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_addr", 32'(rsp_addr), 32'(ea));
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_mem[ea]));
            check("rsp_last", 32'(rsp_last), 32'(k == int'(l)));
            if (k == stall_beat) begin
                rsp_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_addr", 32'(rsp_addr), 32'(ea));
                    check("hold_rdata", 32'(rsp_rdata), 32'(exp_mem[ea]));
                    check("hold_last", 32'(rsp_last), 32'(k == int'(l)));
                    check("hold_addrA", 32'(addrA), 32'(ea));
                end
                rsp_ready = 1'b1;
            end
            tick();
        end
        check("rd_done", 32'(done), 32'd1);
        check("rd_end_nov", 32'(rsp_valid), 32'd0);
        check("rd_end_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i]    = 8'h00;
            exp_mem[i] = 8'h00;
        end
        RST_N = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_wdata = '0; cmd_inc = 1'b0; rsp_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_last", 32'(rsp_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(weA), 32'd0);
        check("rst_addrA", 32'(addrA), 32'd0);
        check("rst_datain", 32'(data_inA), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_raddr", 32'(rsp_addr), 32'd0);
        RST_N = 1'b1;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Incrementing write 0x10..0x13 to 2..5
        do_write(4'd2, 4'd3, 8'h10, 1'b1);
        check("idle_hold_addr", 32'(addrA), 32'd5);
        check("idle_hold_data", 32'(data_inA), 32'h13);

        // Constant write with wrap, read back
        do_write(4'd14, 4'd2, 8'hAA, 1'b0);
        do_read(4'd14, 4'd2, -1, 0);

        // Backpressure on beat 0 of a 2-beat read
        do_read(4'd2, 4'd1, 0, 5);

        // Full-bank walk
        do_write(4'd0, 4'd15, 8'h00, 1'b1);
        do_read(4'd0, 4'd15, -1, 0);

        // Reset at beat 2 of a 16-beat write
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd0; cmd_len = 4'd15;
        cmd_wdata = 8'h55; cmd_inc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("abort_pre_we", 32'(weA), 32'd1);
        check("abort_pre_addr", 32'(addrA), 32'd2);
        #2 RST_N = 1'b0;
        #1;
        check("abort_we", 32'(weA), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_mem[0] = 8'h55;
        exp_mem[1] = 8'h55;
        tick();
        tick();
        check("abort_nodone", 32'(done), 32'd0);
        RST_N = 1'b1;
        tick();
        check("abort_ready_rel", 32'(cmd_ready), 32'd1);
        do_read(4'd0, 4'd3, -1, 0);

        // cmd_valid held high: 2-beat writes accepted only from IDLE
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd8; cmd_len = 4'd1;
        cmd_wdata = 8'h30; cmd_inc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("b2b_ready", 32'(cmd_ready), 32'((i % 3) == 2));
            check("b2b_we", 32'(weA), 32'((i % 3) != 2));
            check("b2b_excl", 32'(cmd_ready & busy), 32'd0);
        end
        cmd_valid = 1'b0;
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_porta_seq.md
REG_BANK_PORTA_SEQ -- requirements
Module: reg_bank_porta_seq

Interface
REQ-001 Parameter ADDR_W, default 4: bank address width; 16 entries.
REQ-002 Parameter DATA_W, default 8: bank data width.
REQ-003 CLKA  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command (registered).
REQ-007 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  ADDR_W  burst start address.
REQ-009 cmd_len  input  4  beats minus one (0..15 -> 1..16 beats).
REQ-010 cmd_wdata  input  DATA_W  write fill value for beat 0.
REQ-011 cmd_inc  input  1  write pattern: 1 = data increments by 1 per beat, 0 = constant.
REQ-012 rsp_valid  output  1  read response beat available.
REQ-013 rsp_ready  input  1  consumer accepts the response beat.
REQ-014 rsp_rdata  output  DATA_W  read data.
REQ-015 rsp_addr  output  ADDR_W  address the data was read from.
REQ-016 rsp_last  output  1  final beat of the burst.
REQ-017 done  output  1  one-cycle pulse when a burst completes.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 addrA  output  ADDR_W  bank port-A address (registered).
REQ-020 data_inA  output  DATA_W  bank port-A write data (registered).
REQ-021 weA  output  1  bank port-A write enable (registered).
REQ-022 data_outA  input  DATA_W  bank port-A read data; valid one CLKA cycle after addrA is presented with weA=0.

Function
REQ-023 States: IDLE, WR, RD_ADDR, RD_WAIT, RD_RESP; the command is accepted on an edge where cmd_valid && cmd_ready.
REQ-024 cmd_ready SHALL be 1 only in IDLE, and SHALL drop to 0 on the accepting edge.
REQ-025 On acceptance, the sequencer SHALL latch addr, len, wdata and inc; cmd_* changes after acceptance SHALL have no effect.
REQ-026 Write: IDLE->WR; beat k drives weA=1, addrA=(cmd_addr+k) mod 16, and data_inA=cmd_wdata+k mod 2^DATA_W if inc, else cmd_wdata.
REQ-027 Write beats SHALL occupy consecutive cycles, one per cycle; a burst of N beats holds weA=1 for exactly N cycles.
REQ-028 After the last write beat: WR->IDLE; that cycle has weA=0, done=1 and cmd_ready=1.
REQ-029 Write bursts SHALL produce no rsp_valid.
REQ-030 Read beat flow:
- RD_ADDR drives addrA with weA=0.
- RD_WAIT follows; data_outA is valid during RD_WAIT and is captured at the end of RD_WAIT.
- RD_RESP follows, with rsp_valid=1.
REQ-031 rsp_rdata, rsp_addr and rsp_last SHALL hold stable while rsp_valid && !rsp_ready (backpressure of any length).
REQ-032 On a response handshake edge:
- if beats remain, go to RD_ADDR with the next address (mod 16);
- on the last beat, go to IDLE with done=1 and rsp_valid=0 in the next cycle.
REQ-033 Minimum read latency SHALL be 3 cycles per beat, from the cycle addrA is driven to the rsp_valid cycle inclusive.
REQ-034 The address SHALL wrap 15->0 within a burst; len=15 covers every entry exactly once.
REQ-035 weA SHALL be 0 in every state other than WR.
REQ-036 addrA and data_inA SHALL hold their last values when idle.
REQ-037 done and rsp_valid SHALL never be high in the same cycle.

Reset
REQ-038 While RST_N=0, outputs SHALL be: state IDLE, cmd_ready=0, rsp_valid=0, rsp_last=0, done=0, busy=0, weA=0, addrA=0, data_inA=0, rsp_rdata=0, rsp_addr=0.
REQ-039 cmd_ready SHALL rise at the first CLKA edge after RST_N deasserts.
REQ-040 Reset asserted mid-burst SHALL abort the burst immediately; weA drops asynchronously and no done pulse occurs.

Verification
REQ-041 Write len=3, addr=2, wdata=0x10, inc=1 -> weA high for 4 cycles writing 0x10..0x13 to 2..5; done one cycle later; no rsp_valid.
REQ-042 Write len=2, addr=14, wdata=0xAA, inc=0, then read len=2, addr=14 -> responses (14,0xAA), (15,0xAA), (0,0xAA,last); address wraps.
REQ-043 Read of 2 beats with rsp_ready held low 5 cycles on beat 0 -> beat 0 held stable for 6 cycles; beat 1 addrA not driven until the handshake.
REQ-044 Write len=15, wdata=0x00, inc=1 from addr 0, then read len=15 -> 16 responses with rdata==addr, rsp_last only on addr 15.
REQ-045 Assert RST_N low at beat 2 of a 16-beat write -> weA=0 at once, cmd_ready=0, busy=0; after release cmd_ready=1 and a new command is accepted.
REQ-046 cmd_valid held high with back-to-back commands -> each accepted only in IDLE cycles, never while busy=1.
